// File: rtl/cpu_loader_pkg.sv
// -----------------------------------------------------------------------------
// cpu_loader_pkg
//   Shared definitions for the boot-time program loader.
//   - state_t              : loader FSM encoding
//   - RUN_CYCLES_W         : width of the run-cycle counter output
//   - RST_CNT_W            : width of the CPU reset hold counter (RST_CYCLES <= 255)
//   - cpu_loader_max_words : instruction-memory capacity in words for a given
//                            word-address width
//   Optional build macro: CPU_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package cpu_loader_pkg;

  localparam int RUN_CYCLES_W = 32;
  localparam int RST_CNT_W    = 8;

  // Encodings are fixed so the CHECK slot stays reserved when the checksum
  // feature is compiled out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_LOAD    = 3'd2,
`ifdef CPU_LOADER_CHECKSUM_EN
    ST_CHECK   = 3'd3,
`endif
    ST_RST_CPU = 3'd4,
    ST_RUN     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // Capacity is returned on 33 bits so that a full 32-bit length word can be
  // compared against it without overflow.
  function automatic logic [32:0] cpu_loader_max_words(input int addr_width);
    cpu_loader_max_words = 33'd1 << addr_width;
  endfunction

endpackage

// File: rtl/cpu_loader_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Parameters:
//     WIDTH  : counter width
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset (count -> 0)
//     clr    : synchronous clear, has priority over en
//     en     : count enable
//     count  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_loader.sv
// -----------------------------------------------------------------------------
// cpu_loader
//   Boot-time program loader placed in front of the five-stage MIPS CPU.
//   Accepts a length-prefixed stream of 32-bit instruction words, writes them
//   into instruction memory from word address 0, then pulses the CPU reset,
//   enables the CPU until it reports HALT and counts the run cycles.
//
//   Stream: length word N, N payload words, and (with CPU_LOADER_CHECKSUM_EN
//   defined) one trailing word that must equal the XOR of the payload.
//
//   Parameters:
//     ADDR_WIDTH : instruction-memory word-address width (capacity 2^ADDR_WIDTH)
//     RST_CYCLES : cycles CPU_RESET is held in RST_CPU (1..255)
//   Ports:
//     CLOCK, RESET         : clock / asynchronous active-low reset
//     START                : starts a load from IDLE, DONE or ERROR
//     S_DATA/S_VALID/S_READY : stream input handshake
//     IM_WE/IM_ADDR/IM_WDATA : instruction-memory write port (registered)
//     CPU_RESET, CPU_ENABLE  : CPU control
//     HALT                 : CPU halt indication, only looked at in RUN
//     BUSY, DONE, ERROR    : status decodes of the FSM state
//     RUN_CYCLES           : saturating count of cycles spent in RUN
//   Build macro: CPU_LOADER_CHECKSUM_EN (enables CHECK state and XOR check).
// -----------------------------------------------------------------------------
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int RST_CYCLES = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [31:0]             S_DATA,
  input  logic                    S_VALID,
  output logic                    S_READY,
  output logic                    IM_WE,
  output logic [ADDR_WIDTH-1:0]   IM_ADDR,
  output logic [31:0]             IM_WDATA,
  output logic                    CPU_RESET,
  output logic                    CPU_ENABLE,
  input  logic                    HALT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  output logic [RUN_CYCLES_W-1:0] RUN_CYCLES
);

  localparam logic [32:0]          MAX_WORDS = cpu_loader_max_words(ADDR_WIDTH);
  localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RST_CYCLES - 1);

  state_t state, next_state;

  logic                  beat;
  logic                  start_go;
  logic                  len_bad;
  logic                  last_beat;
  logic                  in_check;
  logic                  csum_ok;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [RST_CNT_W-1:0]  rst_cnt;
  logic                  run_en;
  logic                  rst_cnt_clr;
  logic                  rst_cnt_en;

  logic                  im_we_p1;
  logic [ADDR_WIDTH-1:0] im_addr_p1;
  logic [31:0]           im_wdata_p1;

  assign beat     = S_VALID && S_READY;
  assign start_go = START && ((state == ST_IDLE) || (state == ST_DONE) ||
                              (state == ST_ERROR));

  // Length 0 and anything beyond capacity are rejected; exactly capacity is legal.
  assign len_bad   = (S_DATA == 32'd0) || ({1'b0, S_DATA} > MAX_WORDS);
  assign last_beat = (word_cnt == (len_q - (ADDR_WIDTH+1)'(1)));

`ifdef CPU_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  assign in_check = (state == ST_CHECK);
  assign csum_ok  = (S_DATA == csum_q);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      csum_q <= '0;
    end else if (start_go) begin
      csum_q <= '0;
    end else if ((state == ST_LOAD) && beat) begin
      csum_q <= csum_q ^ S_DATA;
    end
  end
`else
  assign in_check = 1'b0;
  assign csum_ok  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (START) next_state = ST_LEN;
      end
      ST_LEN: begin
        if (beat) next_state = len_bad ? ST_ERROR : ST_LOAD;
      end
      ST_LOAD: begin
        if (beat && last_beat) begin
`ifdef CPU_LOADER_CHECKSUM_EN
          next_state = ST_CHECK;
`else
          next_state = ST_RST_CPU;
`endif
        end
      end
`ifdef CPU_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (beat) next_state = csum_ok ? ST_RST_CPU : ST_ERROR;
      end
`endif
      ST_RST_CPU: begin
        if (rst_cnt == RST_LAST) next_state = ST_RUN;
      end
      // HALT takes precedence; START is not looked at while running.
      ST_RUN: begin
        if (HALT) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (pure function of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    S_READY    = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ERROR      = 1'b0;
    CPU_RESET  = 1'b1;
    CPU_ENABLE = 1'b0;
    case (state)
      ST_LEN, ST_LOAD: begin
        S_READY = 1'b1;
        BUSY    = 1'b1;
      end
      ST_RST_CPU: begin
        BUSY = 1'b1;
      end
      ST_RUN: begin
        BUSY       = 1'b1;
        CPU_RESET  = 1'b0;
        CPU_ENABLE = 1'b1;
      end
      // CPU state is left untouched so it can be inspected after halt.
      ST_DONE: begin
        DONE      = 1'b1;
        CPU_RESET = 1'b0;
      end
      ST_ERROR: begin
        ERROR = 1'b1;
      end
      default: begin
        if (in_check) begin
          S_READY = 1'b1;
          BUSY    = 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: length latch, word counter and registered memory write
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      len_q       <= '0;
      word_cnt    <= '0;
      im_we_p1    <= 1'b0;
      im_addr_p1  <= '0;
      im_wdata_p1 <= '0;
    end else begin
      im_we_p1 <= 1'b0;
      if (start_go) begin
        word_cnt <= '0;
      end
      if ((state == ST_LEN) && beat) begin
        len_q <= S_DATA[ADDR_WIDTH:0];
      end
      // Address/data hold their last value whenever no write is issued.
      if ((state == ST_LOAD) && beat) begin
        im_we_p1    <= 1'b1;
        im_addr_p1  <= word_cnt[ADDR_WIDTH-1:0];
        im_wdata_p1 <= S_DATA;
        word_cnt    <= word_cnt + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign IM_WE    = im_we_p1;
  assign IM_ADDR  = im_addr_p1;
  assign IM_WDATA = im_wdata_p1;

  // ---------------------------------------------------------------------------
  // Counters: run-cycle count and CPU reset hold
  // ---------------------------------------------------------------------------
  assign run_en      = (state == ST_RUN);
  // The hold counter sits at zero outside RST_CPU so every entry starts fresh.
  assign rst_cnt_clr = (state != ST_RST_CPU);
  assign rst_cnt_en  = (state == ST_RST_CPU);

  sat_counter #(
    .WIDTH (RUN_CYCLES_W)
  ) u_run_cnt (
    .clk   (CLOCK),
    .rst_n (RESET),
    .clr   (start_go),
    .en    (run_en),
    .count (RUN_CYCLES)
  );

  sat_counter #(
    .WIDTH (RST_CNT_W)
  ) u_rst_cnt (
    .clk   (CLOCK),
    .rst_n (RESET),
    .clr   (rst_cnt_clr),
    .en    (rst_cnt_en),
    .count (rst_cnt)
  );

endmodule

// File: tb/tb_cpu_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_loader
//   Directed bench for cpu_loader (ADDR_WIDTH=10, RST_CYCLES=4). Expected
//   memory writes are queued as beats are driven; a negedge monitor records
//   what the DUT writes, and the two are matched in order.
// -----------------------------------------------------------------------------
module tb_cpu_loader;

  localparam int AW   = 10;
  localparam int NMAX = 4096;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          START;
  logic [31:0]   S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic          IM_WE;
  logic [AW-1:0] IM_ADDR;
  logic [31:0]   IM_WDATA;
  logic          CPU_RESET;
  logic          CPU_ENABLE;
  logic          HALT;
  logic          BUSY;
  logic          DONE;
  logic          ERROR;
  logic [31:0]   RUN_CYCLES;

  int checks = 0;
  int errors = 0;

  logic [63:0]   exp_q[$];
  logic [AW-1:0] obs_addr [NMAX];
  logic [31:0]   obs_data [NMAX];
  int            obs_cyc  [NMAX];
  int            obs_n     = 0;
  int            we_pulses = 0;
  int            en_cycles = 0;
  int            cyc       = 0;
  int            rd        = 0;

  cpu_loader #(
    .ADDR_WIDTH (AW),
    .RST_CYCLES (4)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .START      (START),
    .S_DATA     (S_DATA),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .IM_WE      (IM_WE),
    .IM_ADDR    (IM_ADDR),
    .IM_WDATA   (IM_WDATA),
    .CPU_RESET  (CPU_RESET),
    .CPU_ENABLE (CPU_ENABLE),
    .HALT       (HALT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .RUN_CYCLES (RUN_CYCLES)
  );

  always #5 CLOCK = ~CLOCK;

  // Monitor: record every memory write and count enabled cycles.
  always @(negedge CLOCK) begin
    cyc <= cyc + 1;
    if (IM_WE) begin
      we_pulses <= we_pulses + 1;
      if (obs_n < NMAX) begin
        obs_addr[obs_n] <= IM_ADDR;
        obs_data[obs_n] <= IM_WDATA;
        obs_cyc[obs_n]  <= cyc;
        obs_n           <= obs_n + 1;
      end
    end
    if (CPU_ENABLE) en_cycles <= en_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input int addr, input logic [31:0] data);
    mk = (64'(addr) << 32) | 64'(data);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap);
    S_VALID = 1'b0;
    repeat (gap) tick();
    S_DATA  = d;
    S_VALID = 1'b1;
    tick();
    S_VALID = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic load_stream(input logic [31:0] w[$], input int gap, input bit bad_csum);
    logic [31:0] x;
    x = '0;
    do_start();
    send_beat(32'(w.size()), gap);
    for (int i = 0; i < w.size(); i++) begin
      exp_q.push_back(mk(i, w[i]));
      x = x ^ w[i];
      send_beat(w[i], gap);
    end
`ifdef CPU_LOADER_CHECKSUM_EN
    send_beat(bad_csum ? (x ^ 32'd1) : x, gap);
`else
    if (bad_csum) $display("note: checksum word not part of this build");
`endif
  endtask

  task automatic drain(input string tag);
    logic [63:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_n) begin
        chk(tag, mk(int'(obs_addr[rd]), obs_data[rd]), e);
        rd++;
      end else begin
        chk({tag, "_count"}, 64'(obs_n), 64'(rd + 1));
      end
    end
  endtask

  task automatic wait_run(output int rc);
    int k;
    k  = 0;
    rc = 0;
    while (!CPU_ENABLE && k < 2000) begin
      if (CPU_RESET) rc++;
      tick();
      k++;
    end
    chk("run_reached", 64'(CPU_ENABLE), 64'd1);
  endtask

  task automatic halt_at(input int n);
    repeat (n - 1) tick();
    HALT = 1'b1;
    tick();
    HALT = 1'b0;
  endtask

  initial begin
    logic [31:0] w3[$];
    logic [31:0] w3b[$];
    logic [31:0] w5[$];
    logic [31:0] big[$];
    int rc, we0, c0, e0;

    w3  = '{32'h20080005, 32'h20090007, 32'h01095020};
    w3b = '{32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F};
    w5  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    for (int i = 0; i < 1024; i++) big.push_back($urandom());

    RESET = 1'b0; START = 1'b0; S_VALID = 1'b0; S_DATA = '0; HALT = 1'b0;
    repeat (2) tick();
    chk("rst_s_ready", 64'(S_READY), 64'd0);
    chk("rst_ctrl", 64'({IM_WE, CPU_ENABLE, BUSY, DONE, ERROR}), 64'd0);
    chk("rst_cpu_reset", 64'(CPU_RESET), 64'd1);
    chk("rst_im", 64'({IM_ADDR, IM_WDATA}), 64'd0);
    chk("rst_run_cycles", 64'(RUN_CYCLES), 64'd0);
    RESET = 1'b1;
    tick();

    // Continuous three-word load, then halt after 37 RUN cycles.
    we0 = we_pulses; c0 = obs_n;
    load_stream(w3, 0, 1'b0);
    wait_run(rc);
    chk("t1_rst_cycles", 64'(rc), 64'd4);
    chk("t1_cpu_reset_low", 64'(CPU_RESET), 64'd0);
    chk("t1_run_first", 64'(RUN_CYCLES), 64'd0);
    chk("t1_consec1", 64'(obs_cyc[c0+1] - obs_cyc[c0]), 64'd1);
    chk("t1_consec2", 64'(obs_cyc[c0+2] - obs_cyc[c0]), 64'd2);
    drain("t1_write");
    chk("t1_pulses", 64'(we_pulses - we0), 64'd3);
    halt_at(37);
    chk("t1_done", 64'(DONE), 64'd1);
    chk("t1_enable_off", 64'(CPU_ENABLE), 64'd0);
    chk("t1_run_cycles", 64'(RUN_CYCLES), 64'd37);
    repeat (3) tick();
    chk("t1_run_hold", 64'(RUN_CYCLES), 64'd37);
    chk("t1_done_cpu_reset", 64'(CPU_RESET), 64'd0);

    // Same stream with two idle cycles before each beat.
    we0 = we_pulses;
    load_stream(w3, 2, 1'b0);
    wait_run(rc);
    drain("t2_write");
    chk("t2_pulses", 64'(we_pulses - we0), 64'd3);
    HALT = 1'b1; START = 1'b1;
    tick();
    chk("t2_halt_wins", 64'({DONE, BUSY}), 64'b10);
    chk("t2_run_one", 64'(RUN_CYCLES), 64'd1);
    HALT = 1'b0;
    tick();
    START = 1'b0;
    chk("t2_restart_busy", 64'({BUSY, S_READY}), 64'b11);
    chk("t2_restart_clear", 64'(RUN_CYCLES), 64'd0);

    // Illegal lengths, then a normal load.
    e0 = en_cycles; we0 = we_pulses;
    send_beat(32'd0, 0);
    chk("t3_len0_error", 64'({ERROR, CPU_RESET, CPU_ENABLE, S_READY}), 64'b1100);
    repeat (2) tick();
    chk("t3_sticky", 64'(ERROR), 64'd1);
    do_start();
    send_beat(32'd1025, 0);
    chk("t3_len1025_error", 64'({ERROR, CPU_ENABLE}), 64'b10);
    tick();
    chk("t3_no_enable", 64'(en_cycles - e0), 64'd0);
    chk("t3_no_write", 64'(we_pulses - we0), 64'd0);
    load_stream(w3b, 0, 1'b0);
    wait_run(rc);
    chk("t3_rst_cycles", 64'(rc), 64'd4);
    drain("t3_write");
    halt_at(5);
    chk("t3_done", 64'({DONE, RUN_CYCLES[7:0]}), 64'({1'b1, 8'd5}));

    // Full-capacity load: last write lands on 2^AW-1.
    we0 = we_pulses; c0 = obs_n;
    load_stream(big, 0, 1'b0);
    wait_run(rc);
    chk("t4_first_addr", 64'(obs_addr[c0]), 64'd0);
    chk("t4_last_addr", 64'(obs_addr[obs_n-1]), 64'd1023);
    chk("t4_pulses", 64'(we_pulses - we0), 64'd1024);
    drain("t4_write");
    halt_at(2);

`ifdef CPU_LOADER_CHECKSUM_EN
    // Checksum off by one bit, then correct.
    e0 = en_cycles;
    load_stream(w3, 0, 1'b1);
    chk("t5_bad_csum", 64'({ERROR, CPU_RESET}), 64'b11);
    tick();
    chk("t5_no_enable", 64'(en_cycles - e0), 64'd0);
    drain("t5_bad_write");
    load_stream(w3, 0, 1'b0);
    wait_run(rc);
    chk("t5_good_rst_cycles", 64'(rc), 64'd4);
    drain("t5_good_write");
    halt_at(3);
`endif

    // Asynchronous reset after two of five words, then full reload.
    do_start();
    send_beat(32'd5, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(i, w5[i]));
      send_beat(w5[i], 0);
    end
    tick();
    RESET = 1'b0;
    #1;
    chk("t6_async_cpu_reset", 64'(CPU_RESET), 64'd1);
    chk("t6_async_ready", 64'({S_READY, BUSY, IM_WE}), 64'd0);
    chk("t6_async_vals", 64'({IM_ADDR, RUN_CYCLES}), 64'd0);
    drain("t6_partial");
    tick();
    RESET = 1'b1;
    tick();
    we0 = we_pulses;
    load_stream(w5, 0, 1'b0);
    wait_run(rc);
    drain("t6_write");
    chk("t6_pulses", 64'(we_pulses - we0), 64'd5);
    halt_at(4);
    chk("t6_done", 64'({DONE, RUN_CYCLES[7:0]}), 64'({1'b1, 8'd4}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
